// File: rtl/cpu_defs.sv
// Shared datapath definitions: the common data width, divider state
// encodings and the quotient pattern reported for a zero divisor.
package cpu_defs;

  // Common operand width for the multiplier, divider and HI/LO write logic.
  localparam int DATA_WIDTH = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // Divider control states.
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then keep the difference only if the subtraction fits.
module div_step
  import cpu_defs::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Trial subtraction; when it fits, the true difference is below the
  // divisor, so the low WIDTH bits of the wrapped subtraction are exact.
  always_comb begin
    shifted = {rem_i, q_msb_i};
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[WIDTH-1:0] - divisor_i;
    if (fits) begin
      rem_o   = diff;
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted[WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential signed/unsigned divider. Quotient is reported on the LO path
// and remainder on the HI path; one result every WIDTH+2 cycles.
module divider
  import cpu_defs::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient_lo,
  output logic [WIDTH-1:0] remainder_hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_lo_q, quotient_lo_d;
  logic [WIDTH-1:0] remainder_hi_q, remainder_hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  // A single iteration unit, fed from the working registers every cycle.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (quo_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // Next-state logic: latch magnitudes in IDLE, iterate in DIVIDE, and
  // apply signs or the zero-divisor override in FINISH.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    dsr_d          = dsr_q;
    orig_d         = orig_q;
    neg_quo_d      = neg_quo_q;
    neg_rem_d      = neg_rem_q;
    zero_d         = zero_q;
    quotient_lo_d  = quotient_lo_q;
    remainder_hi_d = remainder_hi_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    div_zero_d     = div_zero_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d   = DIV_DIVIDE;
          busy_d    = 1'b1;
          count_d   = '0;
          rem_d     = '0;
          quo_d     = (signed_op && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
          dsr_d     = (signed_op && divisor[WIDTH-1]) ? ('0 - divisor) : divisor;
          orig_d    = dividend;
          neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_op & dividend[WIDTH-1];
          zero_d    = (divisor == '0);
        end
      end
      DIV_DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        if (count_q == LAST_COUNT) begin
          state_d = DIV_FINISH;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DIV_FINISH: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        count_d = '0;
        if (zero_q) begin
          quotient_lo_d  = WIDTH'(DIV_ZERO_QUOTIENT);
          remainder_hi_d = orig_q;
          div_zero_d     = 1'b1;
        end else begin
          quotient_lo_d  = neg_quo_q ? ('0 - quo_q) : quo_q;
          remainder_hi_d = neg_rem_q ? ('0 - rem_q) : rem_q;
          div_zero_d     = 1'b0;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset abandons any division in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= DIV_IDLE;
      count_q        <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dsr_q          <= '0;
      orig_q         <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      zero_q         <= 1'b0;
      quotient_lo_q  <= '0;
      remainder_hi_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      div_zero_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      dsr_q          <= dsr_d;
      orig_q         <= orig_d;
      neg_quo_q      <= neg_quo_d;
      neg_rem_q      <= neg_rem_d;
      zero_q         <= zero_d;
      quotient_lo_q  <= quotient_lo_d;
      remainder_hi_q <= remainder_hi_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      div_zero_q     <= div_zero_d;
    end
  end

  assign quotient_lo  = quotient_lo_q;
  assign remainder_hi = remainder_hi_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero     = div_zero_q;

endmodule
